// File: rtl/soc_reset_pkg.sv
// Shared constants for the SoC reset sequencer: FSM encodings, cause bit
// positions and a helper that sizes the sequencing counter.
package soc_reset_pkg;

  // Sequencer states
  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] STRETCH = 2'd1;
  localparam logic [1:0] PERIPH  = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;

  // Reset-cause bit positions
  localparam int unsigned CAUSE_W   = 4;
  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_WDT = 1;
  localparam int unsigned CAUSE_SW  = 2;
  localparam int unsigned CAUSE_DBG = 3;

  // Cause value forced by a power-on / board reset
  localparam logic [CAUSE_W-1:0] CAUSE_RESET_VAL = CAUSE_W'(1) << CAUSE_POR;

  // Counter width: enough to reach max(a, b)-1, never narrower than one bit
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module reset_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic a_reset_n,
  output logic o_rst_n
);

  logic [STAGES-1:0] r_sync;

  // Shift ones in once the board reset is released
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_n = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: orders peripheral and core reset release after a board
// reset or an on-chip reset request, and keeps a sticky reset-cause register.
module reset_sequencer
  import soc_reset_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned CORE_DELAY     = 8
) (
  input  logic               clk,
  input  logic               a_reset_n,
  input  logic               wdt_expire,
  input  logic               sw_rst_req,
  input  logic               dbg_rst_req,
  input  logic               cause_clr,
  output logic               periph_rst_n,
  output logic               core_rst_n,
  output logic [CAUSE_W-1:0] rst_cause
);

  localparam int unsigned CNT_W = cnt_width(STRETCH_CYCLES, CORE_DELAY);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST    = CNT_W'(CORE_DELAY - 1);

  logic               w_por_sync;
  logic               w_req;
  logic [CAUSE_W-1:0] w_req_bits;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_periph_rst_n;
  logic               w_periph_rst_n_nxt;
  logic               r_core_rst_n;
  logic               w_core_rst_n_nxt;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_cause_nxt;

  reset_synchronizer #(
    .STAGES (2)
  ) u_por_sync (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .o_rst_n   (w_por_sync)
  );

  // Gather request sources into cause-register bit positions
  always_comb begin
    w_req_bits            = '0;
    w_req_bits[CAUSE_WDT] = wdt_expire;
    w_req_bits[CAUSE_SW]  = sw_rst_req;
    w_req_bits[CAUSE_DBG] = dbg_rst_req;
    w_req                 = |w_req_bits;
  end

  // Sequencing FSM next state, counter and cause update
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_periph_rst_n_nxt = r_periph_rst_n;
    w_core_rst_n_nxt   = r_core_rst_n;
    w_cause_nxt        = r_cause;

    case (r_state)
      HOLD: begin
        w_state_nxt = STRETCH;
        w_cnt_nxt   = '0;
      end
      STRETCH: begin
        if (w_req) begin
          // A request restarts the stretch window
          w_cnt_nxt   = '0;
          w_cause_nxt = r_cause | w_req_bits;
        end else if (r_cnt == STRETCH_LAST) begin
          w_state_nxt        = PERIPH;
          w_periph_rst_n_nxt = 1'b1;
          w_cnt_nxt          = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PERIPH: begin
        if (w_req) begin
          w_state_nxt        = STRETCH;
          w_cnt_nxt          = '0;
          w_periph_rst_n_nxt = 1'b0;
          w_cause_nxt        = r_cause | w_req_bits;
        end else if (r_cnt == CORE_LAST) begin
          w_state_nxt      = RUN;
          w_core_rst_n_nxt = 1'b1;
          w_cnt_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (w_req) begin
          // Fresh reset event from run: cause is replaced, not accumulated
          w_state_nxt        = STRETCH;
          w_cnt_nxt          = '0;
          w_periph_rst_n_nxt = 1'b0;
          w_core_rst_n_nxt   = 1'b0;
          w_cause_nxt        = w_req_bits;
        end
      end
      default: begin
        w_state_nxt        = HOLD;
        w_cnt_nxt          = '0;
        w_periph_rst_n_nxt = 1'b0;
        w_core_rst_n_nxt   = 1'b0;
      end
    endcase

    // A simultaneous request takes precedence over a clear
    if (cause_clr && !w_req) begin
      w_cause_nxt = '0;
    end
  end

  // State registers, forced by the synchronized board reset
  always_ff @(posedge clk or negedge w_por_sync) begin
    if (!w_por_sync) begin
      r_state        <= HOLD;
      r_cnt          <= '0;
      r_periph_rst_n <= 1'b0;
      r_core_rst_n   <= 1'b0;
      r_cause        <= CAUSE_RESET_VAL;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_periph_rst_n <= w_periph_rst_n_nxt;
      r_core_rst_n   <= w_core_rst_n_nxt;
      r_cause        <= w_cause_nxt;
    end
  end

  assign periph_rst_n = r_periph_rst_n;
  assign core_rst_n   = r_core_rst_n;
  assign rst_cause    = r_cause;

endmodule
